// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter: queued entry layout,
// the PC register index and the wrap-safe stamp age compare.
package wb_pkg;

    localparam int unsigned WB_DEPTH  = 2;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_REG_W  = 4;
    // Wide enough to order every entry that can be outstanding at once.
    localparam int unsigned STAMP_W   = $clog2(2 * WB_DEPTH) + 1;

    localparam logic [WB_REG_W-1:0] REG_PC = WB_REG_W'(15);

    typedef struct packed {
        logic [WB_REG_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
        logic [STAMP_W-1:0]   stamp;
    } wb_entry_t;

    // True when stamp a was issued before stamp b (modular difference sign).
    function automatic logic stamp_older(input logic [STAMP_W-1:0] a,
                                         input logic [STAMP_W-1:0] b);
        logic [STAMP_W-1:0] diff;
        diff = a - b;
        return diff[STAMP_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester entry FIFO; exposes every slot and its valid bit so the
// arbiter can build the pending-write mask without extra bookkeeping.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  wb_entry_t              i_entry,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic                   o_head_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [DEPTH-1:0]       o_slot_valid,
    output wb_entry_t              o_slots [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] r_vld;
    wb_entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_rd        <= r_rd + 1'b1;
                r_vld[r_rd] <= 1'b0;
            end
            if (w_push) begin
                r_mem[r_wr] <= i_entry;
                r_wr        <= r_wr + 1'b1;
                r_vld[r_wr] <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head       = r_mem[r_rd];
    assign o_head_valid = (r_count != '0);
    assign o_count      = r_count;
    assign o_slot_valid = r_vld;
    assign o_slots      = r_mem;

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the EXE and MEM result paths,
// retiring writes in global accept order and exporting a pending-write mask.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned REG_W  = WB_REG_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [REG_W-1:0]      i_req0_dest,
    input  logic [DATA_W-1:0]     i_req0_data,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [REG_W-1:0]      i_req1_dest,
    input  logic [DATA_W-1:0]     i_req1_data,
    output logic                  o_wb_en,
    output logic [REG_W-1:0]      o_wb_dest,
    output logic [DATA_W-1:0]     o_wb_data,
    output logic [2**REG_W-2:0]   o_pending,
    output logic                  o_drop_r15
);

    localparam int unsigned NUM_PEND = 2**REG_W - 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [STAMP_W-1:0] r_stamp;
    logic               r_wb_en;
    logic [REG_W-1:0]   r_wb_dest;
    logic [DATA_W-1:0]  r_wb_data;
    logic               r_drop;

    wb_entry_t          w_in0;
    wb_entry_t          w_in1;
    wb_entry_t          w_head0;
    wb_entry_t          w_head1;
    wb_entry_t          w_sel;
    wb_entry_t          w_slots0 [DEPTH];
    wb_entry_t          w_slots1 [DEPTH];
    logic [DEPTH-1:0]   w_sv0;
    logic [DEPTH-1:0]   w_sv1;
    logic [CNT_W-1:0]   w_cnt0;
    logic [CNT_W-1:0]   w_cnt1;
    logic               w_hv0;
    logic               w_hv1;
    logic               w_push0;
    logic               w_push1;
    logic               w_sel1;
    logic               w_pop0;
    logic               w_pop1;
    logic               w_any;
    logic               w_is_pc;
    logic [NUM_PEND-1:0] w_pending;

    // Ready depends only on registered occupancy, never on this cycle's valid.
    assign o_req0_ready = (w_cnt0 < FULL_CNT);
    assign o_req1_ready = (w_cnt1 < FULL_CNT);
    assign w_push0      = i_req0_valid && o_req0_ready;
    assign w_push1      = i_req1_valid && o_req1_ready;

    // A same-cycle pair is ordered requester 0 first.
    assign w_in0 = '{dest: i_req0_dest, data: i_req0_data, stamp: r_stamp};
    assign w_in1 = '{dest: i_req1_dest, data: i_req1_data,
                     stamp: r_stamp + STAMP_W'(w_push0)};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo0 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push0),
        .i_entry     (w_in0),
        .i_pop       (w_pop0),
        .o_head      (w_head0),
        .o_head_valid(w_hv0),
        .o_count     (w_cnt0),
        .o_slot_valid(w_sv0),
        .o_slots     (w_slots0)
    );

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo1 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push1),
        .i_entry     (w_in1),
        .i_pop       (w_pop1),
        .o_head      (w_head1),
        .o_head_valid(w_hv1),
        .o_count     (w_cnt1),
        .o_slot_valid(w_sv1),
        .o_slots     (w_slots1)
    );

    always_comb begin
        w_sel1  = w_hv1 && (!w_hv0 || stamp_older(w_head1.stamp, w_head0.stamp));
        w_pop1  = w_sel1;
        w_pop0  = w_hv0 && !w_sel1;
        w_any   = w_hv0 || w_hv1;
        w_sel   = w_sel1 ? w_head1 : w_head0;
        w_is_pc = (w_sel.dest == REG_PC);
    end

    // PC-targeted entries drain through the output stage without a write strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stamp   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_stamp <= r_stamp + STAMP_W'(w_push0) + STAMP_W'(w_push1);
            r_wb_en <= w_any && !w_is_pc;
            r_drop  <= w_any && w_is_pc;
            if (w_any) begin
                r_wb_dest <= w_sel.dest;
                r_wb_data <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int unsigned r = 0; r < NUM_PEND; r++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_sv0[i] && (w_slots0[i].dest == REG_W'(r))) w_pending[r] = 1'b1;
                if (w_sv1[i] && (w_slots1[i].dest == REG_W'(r))) w_pending[r] = 1'b1;
            end
            if (r_wb_en && (r_wb_dest == REG_W'(r))) w_pending[r] = 1'b1;
        end
    end

    assign o_pending  = w_pending;
    assign o_wb_en    = r_wb_en;
    assign o_wb_dest  = r_wb_dest;
    assign o_wb_data  = r_wb_data;
    assign o_drop_r15 = r_drop;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, ordering, backpressure, PC drop and
// mid-operation reset, with hand-computed expectations.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0;
    logic        v1;
    logic        rdy0;
    logic        rdy1;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [31:0] dat0;
    logic [31:0] dat1;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [14:0] pending;
    logic        drop;

    int n_checks;
    int n_fail;

    logic [35:0] got [$];
    logic [35:0] exp_q [$];
    logic [31:0] rf [16];

    wb_arbiter u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req0_valid(v0),
        .o_req0_ready(rdy0),
        .i_req0_dest (d0),
        .i_req0_data (dat0),
        .i_req1_valid(v1),
        .o_req1_ready(rdy1),
        .i_req1_dest (d1),
        .i_req1_data (dat1),
        .o_wb_en     (wb_en),
        .o_wb_dest   (wb_dest),
        .o_wb_data   (wb_data),
        .o_pending   (pending),
        .o_drop_r15  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model and retirement log, fed from the write port.
    always @(posedge clk) begin
        #1;
        if (wb_en) begin
            got.push_back({wb_dest, wb_data});
            rf[wb_dest] = wb_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int i0;
        int i1;
        logic saw_low;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        d0 = '0; d1 = '0; dat0 = '0; dat1 = '0;
        for (int r = 0; r < 16; r++) rf[r] = '0;

        repeat (3) @(negedge clk);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_dest", wb_dest, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_drop", drop, 0);
        check("rst_pending", pending, 0);
        check("rst_ready0", rdy0, 1);
        check("rst_ready1", rdy1, 1);
        rst_n = 1'b1;

        // Single write: one cycle from accept to strobe.
        @(negedge clk);
        v0 = 1'b1; d0 = 4'd3; dat0 = 32'hAAAA_0001;
        check("t1_ready0_pre", rdy0, 1);
        @(negedge clk);
        v0 = 1'b0;
        check("t1_en_accept", wb_en, 0);
        check("t1_pend_accept", pending, 15'h0008);
        check("t1_ready0_post", rdy0, 1);
        @(negedge clk);
        check("t1_en", wb_en, 1);
        check("t1_dest", wb_dest, 3);
        check("t1_data", wb_data, 32'hAAAA_0001);
        check("t1_pend_present", pending, 15'h0008);
        @(negedge clk);
        check("t1_en_fall", wb_en, 0);
        check("t1_pend_clear", pending, 0);

        // Same-cycle pair to one register: requester 0 first.
        v0 = 1'b1; d0 = 4'd2; dat0 = 32'h11;
        v1 = 1'b1; d1 = 4'd2; dat1 = 32'h22;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        check("t2_pend", pending, 15'h0004);
        @(negedge clk);
        check("t2_first_en", wb_en, 1);
        check("t2_first_data", wb_data, 32'h11);
        @(negedge clk);
        check("t2_second_en", wb_en, 1);
        check("t2_second_data", wb_data, 32'h22);
        @(negedge clk);
        check("t2_idle", wb_en, 0);
        check("t2_rf2", rf[2], 32'h22);

        // Older req1 entry waits behind a backlog; newer req0 entry must follow it.
        v0 = 1'b1; d0 = 4'd1; dat0 = 32'h100;
        v1 = 1'b1; d1 = 4'd5; dat1 = 32'h500;
        @(negedge clk);
        v1 = 1'b0; d0 = 4'd6; dat0 = 32'h600;
        @(negedge clk);
        v0 = 1'b0;
        check("t3_r1_dest", wb_dest, 1);
        check("t3_r1_data", wb_data, 32'h100);
        @(negedge clk);
        check("t3_r2_en", wb_en, 1);
        check("t3_r2_dest", wb_dest, 5);
        @(negedge clk);
        check("t3_r3_en", wb_en, 1);
        check("t3_r3_dest", wb_dest, 6);
        @(negedge clk);
        check("t3_idle", wb_en, 0);

        // Both requesters streaming six writes each.
        got.delete();
        exp_q.delete();
        i0 = 0; i1 = 0; saw_low = 1'b0;
        for (int c = 0; c < 60 && (i0 < 6 || i1 < 6); c++) begin
            @(negedge clk);
            v0 = (i0 < 6); d0 = 4'(i0);     dat0 = 32'hA000_0000 + 32'(i0);
            v1 = (i1 < 6); d1 = 4'(8 + i1); dat1 = 32'hB000_0000 + 32'(i1);
            if (!rdy0) saw_low = 1'b1;
            if (v0 && rdy0) begin exp_q.push_back({d0, dat0}); i0++; end
            if (v1 && rdy1) begin exp_q.push_back({d1, dat1}); i1++; end
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        for (int c = 0; c < 40 && got.size() < 12; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t4_ready0_low", saw_low, 1);
        check("t4_accepted", i0 + i1, 12);
        check("t4_retired", got.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < got.size() && k < exp_q.size()) begin
                check($sformatf("t4_order_%0d", k), got[k], exp_q[k]);
            end
        end
        check("t4_pend_idle", pending, 0);

        // PC destination is drained silently.
        got.delete();
        v0 = 1'b1; d0 = 4'd15; dat0 = 32'hDEAD;
        @(negedge clk);
        v0 = 1'b0;
        check("t5_pend_q", pending, 0);
        check("t5_drop_pre", drop, 0);
        @(negedge clk);
        check("t5_en", wb_en, 0);
        check("t5_drop", drop, 1);
        check("t5_pend", pending, 0);
        @(negedge clk);
        check("t5_drop_once", drop, 0);
        check("t5_no_write", got.size(), 0);

        // Reset with three entries outstanding.
        v0 = 1'b1; d0 = 4'd9;  dat0 = 32'h9;
        v1 = 1'b1; d1 = 4'd10; dat1 = 32'hA;
        @(negedge clk);
        v1 = 1'b0; d0 = 4'd11; dat0 = 32'hB;
        @(negedge clk);
        v0 = 1'b0;
        check("t6_pend_full", pending, 15'h0E00);
        check("t6_en_before", wb_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_en_async", wb_en, 0);
        check("t6_pend_async", pending, 0);
        got.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_stale", got.size(), 0);
        check("t6_en_after", wb_en, 0);
        check("t6_ready0_after", rdy0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
